// File: rtl/dffn_reset_release_seq.sv
// rtl/dffn_reset_release_seq.sv - staggered falling-edge release of per-domain active-low resets
// Optional soft-reset request/acknowledge path is compiled in by defining RSTSEQ_SOFTRST_EN.
module dffn_reset_release_seq #(
  parameter int NDOM        = 4,
  parameter int STAGGER     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SOFT_HOLD   = 16,
  localparam int DW         = $clog2(NDOM)
) (
  input  logic            CLKN,
  input  logic            RN,
  input  logic            SREQ,
  input  logic [DW-1:0]   SDOM,
  output logic [NDOM-1:0] RN_DOM,
  output logic            DONE,
  output logic            SACK
);

  localparam int SCW = $clog2(STAGGER + 1);

`ifdef RSTSEQ_SOFTRST_EN
  typedef enum logic [1:0] {HOLD, RELEASE, RUN, SOFT} state_t;
`else
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
`endif

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sync;
  logic [SCW-1:0]         scnt, scnt_d;
  logic [DW-1:0]          idx, idx_d;
  logic [NDOM-1:0]        rn_dom_d;
  logic                   done_d;

`ifdef RSTSEQ_SOFTRST_EN
  localparam int HCW = $clog2(SOFT_HOLD + 1);
  logic [HCW-1:0]         hcnt, hcnt_d;
  logic [DW-1:0]          sdom_q, sdom_d;
  logic                   sack_d;
  logic                   req_go;
  logic [(1<<DW)-1:0]     dom_ok;

  always_comb begin
    for (int i = 0; i < (1 << DW); i++) dom_ok[i] = (i < NDOM);
  end

  assign req_go = SREQ && !SACK;

  always_ff @(negedge CLKN or negedge RN) begin
    if (!RN) begin
      hcnt   <= '0;
      sdom_q <= '0;
      SACK   <= 1'b0;
    end else begin
      hcnt   <= hcnt_d;
      sdom_q <= sdom_d;
      SACK   <= sack_d;
    end
  end
`else
  logic unused_soft;
  assign unused_soft = ^{SREQ, SDOM, SOFT_HOLD[0]};
  assign SACK        = 1'b0;
`endif

  // Deassertion is re-timed to the falling edge; assertion stays asynchronous.
  always_ff @(negedge CLKN or negedge RN) begin
    if (!RN) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(negedge CLKN or negedge RN) begin
    if (!RN) begin
      state  <= HOLD;
      scnt   <= '0;
      idx    <= '0;
      RN_DOM <= '0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_d;
      scnt   <= scnt_d;
      idx    <= idx_d;
      RN_DOM <= rn_dom_d;
      DONE   <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    scnt_d   = scnt;
    idx_d    = idx;
    rn_dom_d = RN_DOM;
    done_d   = DONE;
`ifdef RSTSEQ_SOFTRST_EN
    hcnt_d   = hcnt;
    sdom_d   = sdom_q;
    sack_d   = SACK;
    if (SACK && !SREQ) sack_d = 1'b0;
`endif
    case (state)
      HOLD: begin
        // Leave HOLD on the edge where the chain output turns 1.
        if (sync[SYNC_STAGES-2]) begin
          state_d = RELEASE;
          scnt_d  = '0;
          idx_d   = '0;
        end
      end
      RELEASE: begin
        if (scnt == SCW'(STAGGER - 1)) begin
          scnt_d        = '0;
          rn_dom_d[idx] = 1'b1;
          if (idx == DW'(NDOM - 1)) begin
            done_d  = 1'b1;
            state_d = RUN;
`ifdef RSTSEQ_SOFTRST_EN
            // A request already pending is taken on the final release edge itself.
            if (req_go) begin
              if (dom_ok[SDOM]) begin
                rn_dom_d[SDOM] = 1'b0;
                sdom_d         = SDOM;
                hcnt_d         = '0;
                state_d        = SOFT;
              end else begin
                sack_d = 1'b1;
              end
            end
`endif
          end else begin
            idx_d = idx + 1'b1;
          end
        end else begin
          scnt_d = scnt + 1'b1;
        end
      end
      RUN: begin
`ifdef RSTSEQ_SOFTRST_EN
        if (req_go) begin
          if (dom_ok[SDOM]) begin
            rn_dom_d[SDOM] = 1'b0;
            sdom_d         = SDOM;
            hcnt_d         = '0;
            state_d        = SOFT;
          end else begin
            sack_d = 1'b1;
          end
        end
`endif
      end
`ifdef RSTSEQ_SOFTRST_EN
      SOFT: begin
        if (hcnt == HCW'(SOFT_HOLD - 1)) begin
          rn_dom_d[sdom_q] = 1'b1;
          sack_d           = 1'b1;
          state_d          = RUN;
        end else begin
          hcnt_d = hcnt + 1'b1;
        end
      end
`endif
      default: state_d = HOLD;
    endcase
  end

endmodule

// File: tb/tb_dffn_reset_release_seq.sv
// tb/tb_dffn_reset_release_seq.sv - scoreboard bench for the reset-release sequencer
// Soft-reset expectations are active when RSTSEQ_SOFTRST_EN is defined.
module tb_dffn_reset_release_seq;
  localparam int NDOM        = 4;
  localparam int STAGGER     = 8;
  localparam int SYNC_STAGES = 2;
  localparam int SOFT_HOLD   = 16;
  localparam int DW          = $clog2(NDOM);
  localparam int DE          = SYNC_STAGES + NDOM * STAGGER;

  logic            CLKN = 1'b1;
  logic            RN   = 1'b1;
  logic            SREQ = 1'b0;
  logic [DW-1:0]   SDOM = '0;
  logic [NDOM-1:0] RN_DOM;
  logic            DONE;
  logic            SACK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              en;
    logic [NDOM+1:0] val;
  } exp_t;
  exp_t expq[$];

  logic [NDOM+1:0] last_x;
  logic            mon_on = 1'b0;
  int              ntx;
  int              tr[2], ta[2], td[2], tdom[2];

  dffn_reset_release_seq #(
    .NDOM(NDOM), .STAGGER(STAGGER), .SYNC_STAGES(SYNC_STAGES), .SOFT_HOLD(SOFT_HOLD)
  ) dut (
    .CLKN(CLKN), .RN(RN), .SREQ(SREQ), .SDOM(SDOM),
    .RN_DOM(RN_DOM), .DONE(DONE), .SACK(SACK)
  );

  always #5 CLKN = ~CLKN;

  // Expected {SACK, DONE, RN_DOM} after falling edge e, from the timing rules.
  function automatic logic [NDOM+1:0] exp_out(input int e);
    logic [NDOM-1:0] r;
    logic            dn;
    logic            sk;
    r  = '0;
    sk = 1'b0;
    for (int i = 0; i < NDOM; i++)
      if (e >= SYNC_STAGES + (i + 1) * STAGGER) r[i] = 1'b1;
    dn = (e >= DE);
`ifdef RSTSEQ_SOFTRST_EN
    for (int t = 0; t < ntx; t++) begin
      if (e >= ta[t] && e < ta[t] + SOFT_HOLD) r[tdom[t]] = 1'b0;
      if (e >= ta[t] + SOFT_HOLD && e < td[t]) sk = 1'b1;
    end
`endif
    return {sk, dn, r};
  endfunction

  task automatic chk_reset(input string nm);
    checks++;
    if ({SACK, DONE, RN_DOM} !== '0) begin
      errors++;
      $display("FAIL %s got %b expected %b", nm, {SACK, DONE, RN_DOM}, {(NDOM+2){1'b0}});
    end
  endtask

  // Monitor: every output change must match the next queued expectation.
  initial begin
    logic            rn_s;
    int              cur;
    logic [NDOM+1:0] o;
    logic [NDOM+1:0] prev;
    exp_t            x;
    cur  = 0;
    prev = '0;
    wait (mon_on);
    forever begin
      @(negedge CLKN);
      rn_s = RN;
      #1;
      cur = rn_s ? cur + 1 : 0;
      o   = {SACK, DONE, RN_DOM};
      if (o !== prev) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change edge %0d got %b expected no change", cur, o);
        end else begin
          x = expq.pop_front();
          if (x.en != cur || x.val !== o) begin
            errors++;
            $display("FAIL out_change got edge %0d val %b expected edge %0d val %b",
                     cur, o, x.en, x.val);
          end
        end
        prev = o;
      end
    end
  end

  initial begin
    int              pend, pdom, cut, last, stop;
    logic [NDOM+1:0] x;
    pend = 0;
    pdom = 0;
    #2 RN = 1'b0;
    #1 chk_reset("reset_state");
    last_x = '0;
    mon_on = 1'b1;
    @(posedge CLKN);
    for (int it = 0; it < 12; it++) begin
      // Plan up to two soft-reset transactions for this run.
      ntx = (it < 2) ? 0 : 1 + int'($urandom_range(0, 1));
      if (it == 2) ntx = 2;
      if (pend != 0 && ntx == 0) ntx = 1;
      if (pend != 0) begin
        tr[0] = 1;
        tdom[0] = pdom;
      end else begin
        tr[0] = (it == 2) ? 5 : int'($urandom_range(1, DE + 10));
        tdom[0] = (it == 2) ? 1 : int'($urandom_range(0, NDOM - 1));
      end
      ta[0] = (tr[0] > DE) ? tr[0] : DE;
      td[0] = ta[0] + SOFT_HOLD + int'($urandom_range(1, 4));
      tr[1] = td[0] + 1 + int'($urandom_range(0, 3));
      ta[1] = tr[1];
      td[1] = ta[1] + SOFT_HOLD + int'($urandom_range(1, 4));
      tdom[1] = (it == 2) ? 2 : int'($urandom_range(0, NDOM - 1));
      if (it == 0)      last = DE + 100;
      else if (ntx > 0) last = td[ntx-1] + 3;
      else              last = DE + int'($urandom_range(5, 30));
      if (it == 1)      cut = 20;
      else if (it == 3) cut = ta[0] + 5;
      else if (it >= 4 && $urandom_range(0, 2) == 0) cut = int'($urandom_range(1, last - 1));
      else              cut = 0;
      stop = (cut != 0) ? cut : last;

      RN = 1'b1;
      for (int e = 1; e <= stop; e++) begin
        if (e > 1) @(posedge CLKN);
`ifdef RSTSEQ_SOFTRST_EN
        SREQ = 1'b0;
        SDOM = DW'($urandom_range(0, NDOM - 1));
        for (int t = 0; t < ntx; t++)
          if (e >= tr[t] && e < td[t]) begin
            SREQ = 1'b1;
            SDOM = DW'(tdom[t]);
          end
`else
        if (it % 2 == 0) begin
          SREQ = 1'b1;
          SDOM = '0;
        end else begin
          SREQ = 1'($urandom_range(0, 1));
          SDOM = DW'($urandom_range(0, NDOM - 1));
        end
`endif
        x = exp_out(e);
        if (x !== last_x) begin
          expq.push_back('{en: e, val: x});
          last_x = x;
        end
      end

      @(posedge CLKN);
      RN = 1'b0;
      #1 chk_reset("async_reset");
      if (last_x !== '0) begin
        expq.push_back('{en: 0, val: '0});
        last_x = '0;
      end
`ifdef RSTSEQ_SOFTRST_EN
      pend = SREQ ? 1 : 0;
`else
      pend = 0;
`endif
      pdom = int'(SDOM);
      repeat ($urandom_range(1, 3)) @(posedge CLKN);
    end
    repeat (3) @(posedge CLKN);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d left expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dffn_reset_release_seq.md
# dffn_reset_release_seq

Reset-release sequencer for banks of negative-edge, async-active-low-reset flops. It takes the raw chip reset, synchronises its deassertion to the falling clock edge, and releases NDOM per-domain reset lines one at a time with a fixed stagger, limiting simultaneous-release current and ordering domain start-up. It also lets software pulse a single domain's reset through a four-phase request/acknowledge handshake.

## Interface
- NDOM, 4: number of reset domains (>= 2).
- STAGGER, 8: falling edges between consecutive domain releases (>= 1).
- SYNC_STAGES, 2: reset-deassertion synchroniser depth (>= 2).
- SOFT_HOLD, 16: falling edges a soft-reset domain is held low (>= 1).
- DW: localparam, $clog2(NDOM).

Ports:
- CLKN  in  1  clock; all state updates on the falling edge.
- RN  in  1  reset, asynchronous, active-low.
- SREQ  in  1  soft-reset request, four-phase level.
- SDOM  in  DW  domain index for SREQ; held stable while SREQ is high.
- RN_DOM  out  NDOM  per-domain active-low resets.
- DONE  out  1  initial release sequence complete.
- SACK  out  1  soft-reset acknowledge.

## Operation
- RN low: asynchronously RN_DOM=0, DONE=0, SACK=0, synchroniser cleared, FSM=HOLD, counters=0.
- RN high: a 1 shifts through the SYNC_STAGES-deep chain on falling edges.
- FSM states: HOLD, RELEASE, RUN, SOFT.
- HOLD -> RELEASE: on the edge the chain output becomes 1.
- RELEASE:
  - Stagger counter counts 0..STAGGER-1, then wraps.
  - On each wrap, RN_DOM[idx] is set to 1 and idx increments.
  - When idx reaches NDOM-1 and is released, DONE=1 and FSM -> RUN in the same edge.
- RUN:
  - A request is accepted when SREQ=1 and SACK=0, with SDOM < NDOM.
  - On acceptance: RN_DOM[SDOM]=0, the SDOM value is latched, the hold counter is cleared, and FSM -> SOFT.
- RUN, SDOM >= NDOM: no domain is touched; SACK=1 on the next edge.
- SOFT:
  - Counts SOFT_HOLD edges, then restores the latched domain to 1, sets SACK=1, and returns to RUN.
  - Other domains and DONE are unaffected.
- SACK:
  - Stays 1 until SREQ is sampled 0; it clears on that edge.
  - No new acceptance while SACK=1.
- SREQ during HOLD or RELEASE: ignored until RUN; the request remains pending.
- RN low at any point, including mid-RELEASE or mid-SOFT: the full sequence restarts from HOLD.

## Timing
- Edge numbering: edge 1 is the first falling edge with RN high.
- Synchroniser output reaches 1 at edge SYNC_STAGES.
- RN_DOM[i] rises at edge SYNC_STAGES + (i+1)*STAGGER.
- DONE rises together with RN_DOM[NDOM-1].
- Soft reset, request accepted at edge a:
  - RN_DOM[SDOM] falls at edge a.
  - RN_DOM[SDOM] rises at edge a+SOFT_HOLD, together with SACK.
- SACK falls at the first edge with SREQ=0 after SACK=1.
- Earliest next acceptance: one edge after SACK falls.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- RSTSEQ_SOFTRST_EN defined: soft-reset path, SOFT state and SACK logic are compiled in, as described above.
- RSTSEQ_SOFTRST_EN undefined:
  - SREQ and SDOM remain ports and are ignored.
  - SACK is tied 0.
  - FSM has no SOFT state; RUN is terminal until RN is asserted.

## Test plan
- Defaults, RN released, CLKN running: RN_DOM bits rise at edges 10, 18, 26, 34; DONE rises at edge 34; RN_DOM never shows a non-prefix pattern.
- RN pulsed low at edge 20 (RN_DOM=0011): RN_DOM=0000 and DONE=0 immediately, without waiting for a clock edge; after re-release the sequence repeats at edges 10/18/26/34.
- RSTSEQ_SOFTRST_EN, SREQ=1 with SDOM=2 in RUN at edge a:
  - RN_DOM=1011 from edge a to edge a+15; back to 1111 and SACK=1 at edge a+16.
  - SREQ dropped: SACK=0 on the next edge; DONE stays 1 throughout.
- SREQ held high from edge 5 with SDOM=1: request accepted at edge 34; SACK=1 at edge 50.
- RN asserted mid-SOFT: RN_DOM=0 and SACK=0 at once; the initial sequence reruns and the pending SREQ is served after DONE.
- Macro undefined, SREQ=1 with SDOM=0 in RUN for 100 edges: RN_DOM stays 1111 and SACK stays 0.
